// File: rtl/apb_pkg.sv
// Shared types and constants for the APB memory completer.
// Optional error response is enabled with the APB_SLVERR_EN macro.
package apb_pkg;

  localparam int APB_ADDR_W = 16;
  localparam int APB_DATA_W = 32;
  localparam int WAIT_W     = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

endpackage

// File: rtl/apb_mem_slave_if.sv
// APB bus bundle between a requester and the memory completer.
// PSlvErr is present only when APB_SLVERR_EN is defined.
import apb_pkg::*;

interface apb_mem_slave_if #(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
);
  // Handshake: a transfer is a setup cycle (PSel=1, PEnable=0) followed by
  // access cycles (PSel=1, PEnable=1); it completes in the access cycle where
  // PReady=1, and PRData/PSlvErr are only meaningful in that cycle.
  logic [ADDR_W-1:0] PAddr;
  logic              PWrite;
  logic              PSel;
  logic              PEnable;
  logic [DATA_W-1:0] PWData;
  logic [DATA_W-1:0] PRData;
  logic              PReady;
`ifdef APB_SLVERR_EN
  logic              PSlvErr;
`endif

  modport master (
    output PAddr, PWrite, PSel, PEnable, PWData,
`ifdef APB_SLVERR_EN
    input  PSlvErr,
`endif
    input  PRData, PReady
  );

  modport slave (
    input  PAddr, PWrite, PSel, PEnable, PWData,
`ifdef APB_SLVERR_EN
    output PSlvErr,
`endif
    output PRData, PReady
  );

endinterface

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_W storage: one synchronous write port, combinational read port.
// Contents are intentionally not reset.
import apb_pkg::*;

module apb_mem_array #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = APB_DATA_W,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] memory [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      memory[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = memory[i_raddr];

endmodule

// File: rtl/apb_mem_slave.sv
// APB completer in front of a word-addressed memory with WAIT_STATES extra
// access cycles. APB_SLVERR_EN adds an error response for PAddr >= DEPTH.
import apb_pkg::*;

module apb_mem_slave #(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  apb_mem_slave_if.slave        bus,
  output apb_state_e            o_dbg_state
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [WAIT_W-1:0] WS = WAIT_W'(WAIT_STATES);

  apb_state_e        r_state;
  logic [WAIT_W-1:0] r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic              r_ready;
  logic [DATA_W-1:0] r_rdata;
  logic              r_slverr;

  apb_state_e        w_state_nxt;
  logic [WAIT_W-1:0] w_cnt_nxt;
  logic              w_ready_nxt;
  logic [DATA_W-1:0] w_rdata_nxt;
  logic              w_slverr_nxt;
  logic              w_capture;
  logic              w_we;
  logic              w_setup;
  logic [IDX_W-1:0]  w_raddr;
  logic [DATA_W-1:0] w_mem_rdata;
  logic [DATA_W-1:0] w_load_rdata;
  logic              w_rd_oor;

  assign w_setup = bus.PSel & ~bus.PEnable;
  // The read port serves the setup address when data is due at the setup edge.
  assign w_raddr = w_setup ? bus.PAddr[IDX_W-1:0] : r_idx;

`ifdef APB_SLVERR_EN
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  logic r_oor;
  logic w_setup_oor;
  assign w_setup_oor = ({1'b0, bus.PAddr} >= DEPTH_L);
  assign w_rd_oor    = w_setup ? w_setup_oor : r_oor;
  assign bus.PSlvErr = r_slverr;
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_oor <= w_setup_oor;
    end
  end
`else
  assign w_rd_oor = 1'b0;
`endif

  assign w_load_rdata = w_rd_oor ? '0 : w_mem_rdata;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_ready_nxt  = r_ready;
    w_rdata_nxt  = r_rdata;
    w_slverr_nxt = r_slverr;
    w_capture    = 1'b0;
    w_we         = 1'b0;
    // A setup in either state (re)starts a transfer; a pending one is dropped.
    if (w_setup) begin
      w_state_nxt  = ACCESS;
      w_capture    = 1'b1;
      w_cnt_nxt    = WS;
      w_ready_nxt  = 1'b0;
      w_slverr_nxt = 1'b0;
      if (WAIT_STATES == 0) begin
        w_ready_nxt  = 1'b1;
        w_slverr_nxt = w_rd_oor;
        if (!bus.PWrite) w_rdata_nxt = w_load_rdata;
      end
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = IDLE;
        end
        ACCESS: begin
          if (!bus.PSel) begin
            w_state_nxt  = IDLE;
            w_ready_nxt  = 1'b0;
            w_slverr_nxt = 1'b0;
          end else if (r_ready) begin
            w_we         = r_write & ~r_slverr & ~rst;
            w_state_nxt  = IDLE;
            w_ready_nxt  = 1'b0;
            w_slverr_nxt = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt - WAIT_W'(1);
            if (r_cnt == WAIT_W'(1)) begin
              w_ready_nxt  = 1'b1;
              w_slverr_nxt = w_rd_oor;
              if (!r_write) w_rdata_nxt = w_load_rdata;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_ready  <= 1'b0;
      r_rdata  <= '0;
      r_slverr <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ready  <= w_ready_nxt;
      r_rdata  <= w_rdata_nxt;
      r_slverr <= w_slverr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_idx   <= bus.PAddr[IDX_W-1:0];
      r_write <= bus.PWrite;
      r_wdata <= bus.PWData;
    end
  end

  apb_mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_idx),
    .i_wdata (r_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_mem_rdata)
  );

  assign bus.PRData  = r_rdata;
  assign bus.PReady  = r_ready;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: one instance with no wait states, one with two.
// Read data is checked through an expected-value queue.
import apb_pkg::*;

module tb_apb_mem_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_mem_slave_if #(.ADDR_W(16), .DATA_W(32)) bus0 ();
  apb_mem_slave_if #(.ADDR_W(16), .DATA_W(32)) bus2 ();
  apb_state_e dbg0;
  apb_state_e dbg2;

  apb_mem_slave #(.ADDR_W(16), .DATA_W(32), .DEPTH(256), .WAIT_STATES(0)) mem (
    .clk(clk), .rst(rst), .bus(bus0), .o_dbg_state(dbg0)
  );

  apb_mem_slave #(.ADDR_W(16), .DATA_W(32), .DEPTH(256), .WAIT_STATES(2)) mem_ws2 (
    .clk(clk), .rst(rst), .bus(bus2), .o_dbg_state(dbg2)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  int          waits;
  logic [31:0] rdata;
  logic        slverr;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic set_bus(input bit ws2, input logic sel, input logic en, input logic wr,
                         input logic [15:0] addr, input logic [31:0] data);
    if (ws2) begin
      bus2.PSel = sel; bus2.PEnable = en; bus2.PWrite = wr; bus2.PAddr = addr; bus2.PWData = data;
    end else begin
      bus0.PSel = sel; bus0.PEnable = en; bus0.PWrite = wr; bus0.PAddr = addr; bus0.PWData = data;
    end
  endtask

  function automatic logic get_ready(input bit ws2);
    return ws2 ? bus2.PReady : bus0.PReady;
  endfunction

  function automatic logic [31:0] get_rdata(input bit ws2);
    return ws2 ? bus2.PRData : bus0.PRData;
  endfunction

  function automatic logic get_slverr(input bit ws2);
`ifdef APB_SLVERR_EN
    return ws2 ? bus2.PSlvErr : bus0.PSlvErr;
`else
    return 1'b0;
`endif
  endfunction

  task automatic bus_idle(input bit ws2);
    set_bus(ws2, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    @(posedge clk); #1;
  endtask

  // Full transfer: reports access cycles spent with PReady low (bounded).
  task automatic apb_xfer(input bit ws2, input logic wr, input logic [15:0] addr,
                          input logic [31:0] data, output int n_wait,
                          output logic [31:0] rd, output logic err);
    n_wait = 0;
    set_bus(ws2, 1'b1, 1'b0, wr, addr, data);
    @(posedge clk); #1;
    set_bus(ws2, 1'b1, 1'b1, wr, addr, data);
    while (!get_ready(ws2) && n_wait < 20) begin
      n_wait++;
      @(posedge clk); #1;
    end
    rd  = get_rdata(ws2);
    err = get_slverr(ws2);
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    set_bus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus0.PReady !== 1'b0) $display("FAIL reset_pready: got %b expected 0", bus0.PReady); else n_pass++;
    n_checks++; if (bus0.PRData !== 32'h0) $display("FAIL reset_prdata: got %h expected 0", bus0.PRData); else n_pass++;
    n_checks++; if (dbg0 !== IDLE) $display("FAIL reset_state: got %0d expected IDLE", dbg0); else n_pass++;
    n_checks++; if (bus2.PReady !== 1'b0) $display("FAIL reset_pready_ws2: got %b expected 0", bus2.PReady); else n_pass++;
`ifdef APB_SLVERR_EN
    n_checks++; if (bus0.PSlvErr !== 1'b0) $display("FAIL reset_pslverr: got %b expected 0", bus0.PSlvErr); else n_pass++;
`endif
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ws0_write_read();
    apb_xfer(1'b0, 1'b1, 16'h50, 32'h50, waits, rdata, slverr);
    n_checks++; if (waits !== 0) $display("FAIL ws0_write_waits: got %0d expected 0", waits); else n_pass++;
    exp_q.push_back(32'h50);
    apb_xfer(1'b0, 1'b0, 16'h50, 32'h0, waits, rdata, slverr);
    exp_v = exp_q.pop_front();
    n_checks++; if (waits !== 0) $display("FAIL ws0_read_waits: got %0d expected 0", waits); else n_pass++;
    n_checks++; if (rdata !== exp_v) $display("FAIL ws0_read_data: got %h expected %h", rdata, exp_v); else n_pass++;
    n_checks++; if (mem.u_array.memory[8'h50] !== 32'h50)
      $display("FAIL ws0_mem_50: got %h expected 00000050", mem.u_array.memory[8'h50]); else n_pass++;
  endtask

  task automatic test_rdata_hold();
    apb_xfer(1'b0, 1'b1, 16'h51, 32'h77, waits, rdata, slverr);
    n_checks++; if (bus0.PRData !== 32'h50) $display("FAIL rdata_hold: got %h expected 00000050", bus0.PRData); else n_pass++;
    bus_idle(1'b0);
  endtask

  task automatic test_ws2_read();
    apb_xfer(1'b1, 1'b1, 16'h10, 32'hDEADBEEF, waits, rdata, slverr);
    n_checks++; if (waits !== 2) $display("FAIL ws2_write_waits: got %0d expected 2", waits); else n_pass++;
    exp_q.push_back(32'hDEADBEEF);
    apb_xfer(1'b1, 1'b0, 16'h10, 32'h0, waits, rdata, slverr);
    exp_v = exp_q.pop_front();
    n_checks++; if (waits !== 2) $display("FAIL ws2_read_waits: got %0d expected 2", waits); else n_pass++;
    n_checks++; if (rdata !== exp_v) $display("FAIL ws2_read_data: got %h expected %h", rdata, exp_v); else n_pass++;
  endtask

  task automatic test_abort();
    apb_xfer(1'b1, 1'b1, 16'h20, 32'h5555, waits, rdata, slverr);
    set_bus(1'b1, 1'b1, 1'b0, 1'b1, 16'h20, 32'h1234);
    @(posedge clk); #1;
    set_bus(1'b1, 1'b1, 1'b1, 1'b1, 16'h20, 32'h1234);
    @(posedge clk); #1;
    n_checks++; if (bus2.PReady !== 1'b0) $display("FAIL abort_pready_access: got %b expected 0", bus2.PReady); else n_pass++;
    set_bus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
    @(posedge clk); #1;
    n_checks++; if (bus2.PReady !== 1'b0) $display("FAIL abort_pready_after: got %b expected 0", bus2.PReady); else n_pass++;
    n_checks++; if (dbg2 !== IDLE) $display("FAIL abort_state: got %0d expected IDLE", dbg2); else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (mem_ws2.u_array.memory[8'h20] !== 32'h5555)
      $display("FAIL abort_mem_20: got %h expected 00005555", mem_ws2.u_array.memory[8'h20]); else n_pass++;
    exp_q.push_back(32'h5555);
    apb_xfer(1'b1, 1'b0, 16'h20, 32'h0, waits, rdata, slverr);
    exp_v = exp_q.pop_front();
    n_checks++; if (waits !== 2) $display("FAIL abort_next_waits: got %0d expected 2", waits); else n_pass++;
    n_checks++; if (rdata !== exp_v) $display("FAIL abort_next_data: got %h expected %h", rdata, exp_v); else n_pass++;
    bus_idle(1'b1);
  endtask

  task automatic test_reset_mid();
    apb_xfer(1'b0, 1'b1, 16'h30, 32'h1111, waits, rdata, slverr);
    exp_q.push_back(32'h1111);
    apb_xfer(1'b0, 1'b0, 16'h30, 32'h0, waits, rdata, slverr);
    exp_v = exp_q.pop_front();
    n_checks++; if (rdata !== exp_v) $display("FAIL rstmid_pre_read: got %h expected %h", rdata, exp_v); else n_pass++;
    set_bus(1'b0, 1'b1, 1'b0, 1'b1, 16'h30, 32'h9999);
    @(posedge clk); #1;
    set_bus(1'b0, 1'b1, 1'b1, 1'b1, 16'h30, 32'h9999);
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus0.PReady !== 1'b0) $display("FAIL rstmid_pready: got %b expected 0", bus0.PReady); else n_pass++;
    n_checks++; if (bus0.PRData !== 32'h0) $display("FAIL rstmid_prdata: got %h expected 0", bus0.PRData); else n_pass++;
    n_checks++; if (dbg0 !== IDLE) $display("FAIL rstmid_state: got %0d expected IDLE", dbg0); else n_pass++;
    n_checks++; if (mem.u_array.memory[8'h30] !== 32'h1111)
      $display("FAIL rstmid_mem_30: got %h expected 00001111", mem.u_array.memory[8'h30]); else n_pass++;
    rst = 1'b0;
    bus_idle(1'b0);
  endtask

  task automatic test_back_to_back();
    apb_xfer(1'b0, 1'b1, 16'h01, 32'hA, waits, rdata, slverr);
    apb_xfer(1'b0, 1'b1, 16'h02, 32'hB, waits, rdata, slverr);
    exp_q.push_back(32'hA);
    apb_xfer(1'b0, 1'b0, 16'h01, 32'h0, waits, rdata, slverr);
    exp_v = exp_q.pop_front();
    n_checks++; if (waits !== 0) $display("FAIL b2b_read_waits: got %0d expected 0", waits); else n_pass++;
    n_checks++; if (rdata !== exp_v) $display("FAIL b2b_read_data: got %h expected %h", rdata, exp_v); else n_pass++;
    n_checks++; if (mem.u_array.memory[8'h01] !== 32'hA)
      $display("FAIL b2b_mem_01: got %h expected 0000000a", mem.u_array.memory[8'h01]); else n_pass++;
    n_checks++; if (mem.u_array.memory[8'h02] !== 32'hB)
      $display("FAIL b2b_mem_02: got %h expected 0000000b", mem.u_array.memory[8'h02]); else n_pass++;
    bus_idle(1'b0);
  endtask

  task automatic test_slverr();
    apb_xfer(1'b0, 1'b1, 16'h0000, 32'hC0C0, waits, rdata, slverr);
    apb_xfer(1'b0, 1'b1, 16'h0100, 32'hBAD, waits, rdata, slverr);
`ifdef APB_SLVERR_EN
    n_checks++; if (slverr !== 1'b1) $display("FAIL slverr_write_flag: got %b expected 1", slverr); else n_pass++;
    n_checks++; if (waits !== 0) $display("FAIL slverr_write_waits: got %0d expected 0", waits); else n_pass++;
    n_checks++; if (bus0.PSlvErr !== 1'b0) $display("FAIL slverr_clear: got %b expected 0", bus0.PSlvErr); else n_pass++;
    n_checks++; if (mem.u_array.memory[8'h00] !== 32'hC0C0)
      $display("FAIL slverr_mem_00: got %h expected 0000c0c0", mem.u_array.memory[8'h00]); else n_pass++;
    exp_q.push_back(32'h0);
    apb_xfer(1'b0, 1'b0, 16'h0100, 32'h0, waits, rdata, slverr);
    exp_v = exp_q.pop_front();
    n_checks++; if (slverr !== 1'b1) $display("FAIL slverr_read_flag: got %b expected 1", slverr); else n_pass++;
    n_checks++; if (rdata !== exp_v) $display("FAIL slverr_read_data: got %h expected %h", rdata, exp_v); else n_pass++;
`else
    n_checks++; if (mem.u_array.memory[8'h00] !== 32'hBAD)
      $display("FAIL wrap_mem_00: got %h expected 00000bad", mem.u_array.memory[8'h00]); else n_pass++;
    exp_q.push_back(32'hBAD);
    apb_xfer(1'b0, 1'b0, 16'h0100, 32'h0, waits, rdata, slverr);
    exp_v = exp_q.pop_front();
    n_checks++; if (rdata !== exp_v) $display("FAIL wrap_read_data: got %h expected %h", rdata, exp_v); else n_pass++;
`endif
    bus_idle(1'b0);
  endtask

  task automatic test_random();
    logic [31:0] model [256];
    logic [15:0] addrs [8];
    logic [15:0] a;
    logic [31:0] d;
    int          k;
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom_range(16'h80, 16'hFF));
      d = $urandom;
      addrs[i] = a;
      model[a[7:0]] = d;
      apb_xfer(1'b0, 1'b1, a, d, waits, rdata, slverr);
      k = $urandom_range(0, i);
      exp_q.push_back(model[addrs[k][7:0]]);
      apb_xfer(1'b0, 1'b0, addrs[k], 32'h0, waits, rdata, slverr);
      exp_v = exp_q.pop_front();
      n_checks++; if (rdata !== exp_v)
        $display("FAIL rand_read_%0d: addr %h got %h expected %h", i, addrs[k], rdata, exp_v); else n_pass++;
    end
    bus_idle(1'b0);
  endtask

  initial begin
    test_reset();
    test_ws0_write_read();
    test_rdata_hold();
    test_ws2_read();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_slverr();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
